// File: rtl/pong_match_controller_if.sv
// Signal bundle between the pong top level and the match controller.
//   in_animate        1-cycle end-of-frame strobe
//   in_start          START button level (already synchronised)
//   in_left_score     ball flag: left player scored (level)
//   in_right_score    ball flag: right player scored (level)
//   out_left_points   left player points
//   out_right_points  right player points
//   out_state         00 IDLE, 01 PLAY, 10 POINT, 11 GAMEOVER
//   out_winner        00 none, 01 left, 10 right
//   out_serve         1-cycle serve pulse to the animators
//   out_freeze        bars/ball held still while high
// master: the side driving the inputs (top level / bench); slave: the controller.
interface pong_match_controller_if;
  logic       in_animate;
  logic       in_start;
  logic       in_left_score;
  logic       in_right_score;
  logic [3:0] out_left_points;
  logic [3:0] out_right_points;
  logic [1:0] out_state;
  logic [1:0] out_winner;
  logic       out_serve;
  logic       out_freeze;

  modport master (
    output in_animate, in_start, in_left_score, in_right_score,
    input  out_left_points, out_right_points, out_state, out_winner,
           out_serve, out_freeze
  );

  modport slave (
    input  in_animate, in_start, in_left_score, in_right_score,
    output out_left_points, out_right_points, out_state, out_winner,
           out_serve, out_freeze
  );
endinterface

// File: rtl/pong_match_controller.sv
// Match/score controller for the pong game. Counts points from the ball's
// score flags (rising edges only), runs the IDLE/PLAY/POINT/GAMEOVER flow,
// and drives a serve pulse and a freeze flag back to the bar/ball animators.
// Ports:
//   in_clock  board clock (50 MHz), the only clock
//   in_reset  synchronous, active-high reset; aborts a match immediately
//   bus       pong_match_controller_if.slave (see interface file for signals)
// Parameters:
//   WIN_POINTS   points that end the match (1..15)
//   HOLD_FRAMES  animate strobes to pause after a point before re-serving (0..255)
module pong_match_controller #(
  parameter int WIN_POINTS  = 7,
  parameter int HOLD_FRAMES = 60
) (
  input  logic                          in_clock,
  input  logic                          in_reset,
  pong_match_controller_if.slave        bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_POINT = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  localparam logic [3:0] WIN_PTS  = 4'(WIN_POINTS);
  localparam logic [7:0] HOLD_CNT = 8'(HOLD_FRAMES);

  state_t     state_q, state_d;
  logic [3:0] left_q, left_d;
  logic [3:0] right_q, right_d;
  logic [1:0] winner_q, winner_d;
  logic [7:0] hold_q, hold_d;
  logic       serve_q, serve_d;
  logic       freeze_q;
  logic       start_q, lscore_q, rscore_q;

  logic rise_start, rise_left, rise_right;

  // Edge flops track their inputs in every state, so a flag that rose while
  // ignored (POINT/GAMEOVER) still has to fall and rise again to count.
  assign rise_start = bus.in_start       & ~start_q;
  assign rise_left  = bus.in_left_score  & ~lscore_q;
  assign rise_right = bus.in_right_score & ~rscore_q;

  always_comb begin
    state_d  = state_q;
    left_d   = left_q;
    right_d  = right_q;
    winner_d = winner_q;
    hold_d   = hold_q;
    serve_d  = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (rise_start) begin
          left_d   = 4'd0;
          right_d  = 4'd0;
          winner_d = 2'b00;
          serve_d  = 1'b1;
          state_d  = S_PLAY;
        end
      end
      S_PLAY: begin
        // Left has priority when both flags rise together; right is dropped.
        if (rise_left) begin
          left_d = left_q + 4'd1;
          if (left_d == WIN_PTS) begin
            state_d  = S_OVER;
            winner_d = 2'b01;
          end else begin
            state_d = S_POINT;
            hold_d  = HOLD_CNT;
          end
        end else if (rise_right) begin
          right_d = right_q + 4'd1;
          if (right_d == WIN_PTS) begin
            state_d  = S_OVER;
            winner_d = 2'b10;
          end else begin
            state_d = S_POINT;
            hold_d  = HOLD_CNT;
          end
        end
      end
      S_POINT: begin
        // Count down on frame strobes; the strobe seen at zero re-serves.
        if (bus.in_animate) begin
          if (hold_q == 8'd0) begin
            serve_d = 1'b1;
            state_d = S_PLAY;
          end else begin
            hold_d = hold_q - 8'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q  <= S_IDLE;
      left_q   <= 4'd0;
      right_q  <= 4'd0;
      winner_q <= 2'b00;
      hold_q   <= 8'd0;
      serve_q  <= 1'b0;
      freeze_q <= 1'b1;
      start_q  <= 1'b0;
      lscore_q <= 1'b0;
      rscore_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      left_q   <= left_d;
      right_q  <= right_d;
      winner_q <= winner_d;
      hold_q   <= hold_d;
      serve_q  <= serve_d;
      freeze_q <= (state_d != S_PLAY);
      start_q  <= bus.in_start;
      lscore_q <= bus.in_left_score;
      rscore_q <= bus.in_right_score;
    end
  end

  assign bus.out_state        = state_q;
  assign bus.out_left_points  = left_q;
  assign bus.out_right_points = right_q;
  assign bus.out_winner       = winner_q;
  assign bus.out_serve        = serve_q;
  assign bus.out_freeze       = freeze_q;

endmodule

// File: tb/tb_pong_match_controller.sv
// Directed bench for pong_match_controller with default parameters
// (WIN_POINTS=7, HOLD_FRAMES=60).
module tb_pong_match_controller;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_mis;

  pong_match_controller_if bus ();

  pong_match_controller #(
    .WIN_POINTS  (7),
    .HOLD_FRAMES (60)
  ) dut (
    .in_clock (clk),
    .in_reset (rst),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are settled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic [3:0] l,
                         input logic [3:0] r, input logic [1:0] w, input logic sv);
    chk({tag, ".state"},  8'(bus.out_state), 8'(st));
    chk({tag, ".left"},   8'(bus.out_left_points), 8'(l));
    chk({tag, ".right"},  8'(bus.out_right_points), 8'(r));
    chk({tag, ".winner"}, 8'(bus.out_winner), 8'(w));
    chk({tag, ".serve"},  8'(bus.out_serve), 8'(sv));
    chk({tag, ".freeze"}, 8'(bus.out_freeze), 8'(st != 2'b01));
  endtask

  task automatic animate_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_animate = 1'b1;
      step();
      bus.in_animate = 1'b0;
    end
  endtask

  // Reset, then start a fresh match; leaves the controller in PLAY at 0/0.
  task automatic start_match();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.in_start = 1'b1;
    step();
    bus.in_start = 1'b0;
    step();
  endtask

  // From POINT with a full hold loaded: 60 strobes keep POINT, the 61st serves.
  task automatic hold_out(input string tag, input logic [3:0] l, input logic [3:0] r);
    animate_n(60);
    chk_all({tag, ".hold60"}, 2'b10, l, r, 2'b00, 1'b0);
    animate_n(1);
    chk_all({tag, ".serve"}, 2'b01, l, r, 2'b00, 1'b1);
    step();
    chk({tag, ".serve_off"}, 8'(bus.out_serve), 8'd0);
  endtask

  initial begin
    n_vec = 0;
    n_mis = 0;
    rst = 1'b1;
    bus.in_animate     = 1'b0;
    bus.in_start       = 1'b0;
    bus.in_left_score  = 1'b0;
    bus.in_right_score = 1'b0;
    step();
    step();
    chk_all("reset", 2'b00, 4'd0, 4'd0, 2'b00, 1'b0);
    rst = 1'b0;

    // 1: start from IDLE
    step();
    chk_all("idle_wait", 2'b00, 4'd0, 4'd0, 2'b00, 1'b0);
    bus.in_start = 1'b1;
    step();
    chk_all("t1.start", 2'b01, 4'd0, 4'd0, 2'b00, 1'b1);
    step();
    chk_all("t1.after", 2'b01, 4'd0, 4'd0, 2'b00, 1'b0);
    bus.in_start = 1'b0;

    // 2: held left flag counts once, then hold and re-serve
    bus.in_left_score = 1'b1;
    step();
    chk_all("t2.point", 2'b10, 4'd1, 4'd0, 2'b00, 1'b0);
    for (int i = 0; i < 9; i++) step();
    chk_all("t2.held", 2'b10, 4'd1, 4'd0, 2'b00, 1'b0);
    bus.in_left_score = 1'b0;
    step();
    hold_out("t2", 4'd1, 4'd0);

    // 3: simultaneous rises, left wins priority
    start_match();
    chk_all("t3.fresh", 2'b01, 4'd0, 4'd0, 2'b00, 1'b0);
    bus.in_left_score  = 1'b1;
    bus.in_right_score = 1'b1;
    step();
    chk_all("t3.both", 2'b10, 4'd1, 4'd0, 2'b00, 1'b0);
    bus.in_left_score  = 1'b0;
    bus.in_right_score = 1'b0;

    // 5: rises during POINT ignored, countdown unaffected (10 + 50 + 1)
    animate_n(10);
    bus.in_left_score  = 1'b1;
    bus.in_right_score = 1'b1;
    bus.in_start       = 1'b1;
    step();
    chk_all("t5.ignored", 2'b10, 4'd1, 4'd0, 2'b00, 1'b0);
    bus.in_left_score  = 1'b0;
    bus.in_right_score = 1'b0;
    bus.in_start       = 1'b0;
    step();
    animate_n(50);
    chk_all("t5.hold", 2'b10, 4'd1, 4'd0, 2'b00, 1'b0);
    animate_n(1);
    chk_all("t5.serve", 2'b01, 4'd1, 4'd0, 2'b00, 1'b1);
    step();

    // 4: right wins the match, then GAMEOVER behaviour and restart
    start_match();
    for (int k = 1; k <= 7; k++) begin
      bus.in_right_score = 1'b1;
      step();
      bus.in_right_score = 1'b0;
      if (k < 7) begin
        chk_all("t4.point", 2'b10, 4'd0, 4'(k), 2'b00, 1'b0);
        hold_out("t4", 4'd0, 4'(k));
      end
    end
    chk_all("t4.over", 2'b11, 4'd0, 4'd7, 2'b10, 1'b0);
    step();
    bus.in_left_score = 1'b1;
    step();
    bus.in_left_score = 1'b0;
    bus.in_right_score = 1'b1;
    step();
    bus.in_right_score = 1'b0;
    step();
    chk_all("t4.ignored", 2'b11, 4'd0, 4'd7, 2'b10, 1'b0);
    bus.in_start = 1'b1;
    step();
    chk_all("t4.restart", 2'b01, 4'd0, 4'd0, 2'b00, 1'b1);
    bus.in_start = 1'b0;
    step();
    chk("t4.serve_off", 8'(bus.out_serve), 8'd0);

    // 6: reset during POINT at left=3
    start_match();
    for (int k = 1; k <= 3; k++) begin
      bus.in_left_score = 1'b1;
      step();
      bus.in_left_score = 1'b0;
      if (k < 3) hold_out("t6", 4'(k), 4'd0);
    end
    chk_all("t6.pre", 2'b10, 4'd3, 4'd0, 2'b00, 1'b0);
    rst = 1'b1;
    step();
    chk_all("t6.reset", 2'b00, 4'd0, 4'd0, 2'b00, 1'b0);
    rst = 1'b0;
    step();
    chk_all("t6.idle", 2'b00, 4'd0, 4'd0, 2'b00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
